// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG sequencing controller.
package jtag_pkg;

    localparam int unsigned DEF_MAX_LEN = 32;
    localparam int unsigned DEF_LEN_W   = 6;

    // Host command opcodes
    typedef enum logic [1:0] {
        OP_TLR = 2'b00,
        OP_IR  = 2'b01,
        OP_DR  = 2'b10,
        OP_RUN = 2'b11
    } jtag_op_t;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_NAV,
        ST_SHIFT,
        ST_EXIT,
        ST_RUN,
        ST_RESP
    } ctrl_state_t;

    // IEEE 1149.1 TAP states, 4-bit encodings
    typedef enum logic [3:0] {
        TAP_TLR    = 4'b0000,
        TAP_IDLE   = 4'b0001,
        TAP_SEL_DR = 4'b0011,
        TAP_CAP_DR = 4'b0010,
        TAP_SHI_DR = 4'b0110,
        TAP_EX1_DR = 4'b0111,
        TAP_PAU_DR = 4'b0101,
        TAP_EX2_DR = 4'b0100,
        TAP_UPD_DR = 4'b1001,
        TAP_SEL_IR = 4'b1011,
        TAP_CAP_IR = 4'b1010,
        TAP_SHI_IR = 4'b1110,
        TAP_EX1_IR = 4'b1111,
        TAP_PAU_IR = 4'b1101,
        TAP_EX2_IR = 4'b1100,
        TAP_UPD_IR = 4'b1000
    } tap_state_t;

    // Idle -> Shift-xR TMS walks, bit0 driven first
    localparam logic [3:0]  NAV_IR_TMS = 4'b0011;
    localparam int unsigned NAV_IR_LEN = 4;
    localparam logic [3:0]  NAV_DR_TMS = 4'b0001;
    localparam int unsigned NAV_DR_LEN = 3;

    // TAP next-state on one TCK with the given TMS
    function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
        tap_state_t n;
        case (s)
            TAP_TLR:    n = t ? TAP_TLR    : TAP_IDLE;
            TAP_IDLE:   n = t ? TAP_SEL_DR : TAP_IDLE;
            TAP_SEL_DR: n = t ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: n = t ? TAP_EX1_DR : TAP_SHI_DR;
            TAP_SHI_DR: n = t ? TAP_EX1_DR : TAP_SHI_DR;
            TAP_EX1_DR: n = t ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: n = t ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: n = t ? TAP_UPD_DR : TAP_SHI_DR;
            TAP_UPD_DR: n = t ? TAP_SEL_DR : TAP_IDLE;
            TAP_SEL_IR: n = t ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: n = t ? TAP_EX1_IR : TAP_SHI_IR;
            TAP_SHI_IR: n = t ? TAP_EX1_IR : TAP_SHI_IR;
            TAP_EX1_IR: n = t ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: n = t ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: n = t ? TAP_UPD_IR : TAP_SHI_IR;
            TAP_UPD_IR: n = t ? TAP_SEL_DR : TAP_IDLE;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// TDI parallel-in/serial-out and TDO serial-in (indexed) capture register.
module jtag_shift_reg
    import jtag_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       load_i,
    input  logic [MAX_LEN-1:0]         load_data_i,
    input  logic                       shift_i,
    input  logic                       cap_i,
    input  logic [$clog2(MAX_LEN)-1:0] cap_idx_i,
    input  logic                       tdo_i,
    output logic                       lsb_o,
    output logic [MAX_LEN-1:0]         capt_o
);

    logic [MAX_LEN-1:0] piso_q;
    logic [MAX_LEN-1:0] sipo_q;

    // Load clears the capture side so unshifted bits read back as zero
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            piso_q <= '0;
            sipo_q <= '0;
        end else if (load_i) begin
            piso_q <= load_data_i;
            sipo_q <= '0;
        end else begin
            if (shift_i) piso_q <= piso_q >> 1;
            if (cap_i)   sipo_q[cap_idx_i] <= tdo_i;
        end
    end

    assign lsb_o  = piso_q[0];
    assign capt_o = sipo_q;

endmodule

// File: rtl/jtag_seq_ctrl.sv
// Command-driven JTAG master: walks the TAP with TMS, shifts TDI LSB-first, returns TDO.
module jtag_seq_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN);

    ctrl_state_t      state_q;
    tap_state_t       tap_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             ir_q;
    logic             tlr_q;
    logic             tms_q;
    logic             tdi_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             busy_q;
    logic             cap_q;
    logic [IDX_W-1:0] cap_idx_q;

    logic             accept;
    logic             len_bad;
    logic             bit_go;
    logic             sr_lsb;
    logic [3:0]       nav_tms;
    logic [LEN_W-1:0] nav_len;

    assign accept  = cmd_valid & cmd_ready_q;
    assign len_bad = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
    assign nav_tms = ir_q ? NAV_IR_TMS : NAV_DR_TMS;
    assign nav_len = ir_q ? LEN_W'(NAV_IR_LEN) : LEN_W'(NAV_DR_LEN);
    // A shift bit is driven on this edge (first bit leaves NAV, the rest stay in SHIFT)
    assign bit_go  = ((state_q == ST_NAV) && (cnt_q == nav_len)) ||
                     ((state_q == ST_SHIFT) && (cnt_q != len_q));

    jtag_shift_reg #(.MAX_LEN(MAX_LEN)) u_sr (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (accept),
        .load_data_i (cmd_data),
        .shift_i     (bit_go),
        .cap_i       (cap_q),
        .cap_idx_i   (cap_idx_q),
        .tdo_i       (tdo),
        .lsb_o       (sr_lsb),
        .capt_o      (rsp_data)
    );

    // Sequencer: TMS walk, TDI drive, delayed TDO capture strobe, host handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            tap_q       <= TAP_TLR;
            cnt_q       <= '0;
            len_q       <= '0;
            ir_q        <= 1'b0;
            tlr_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
            cap_q       <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            tap_q <= tap_next(tap_q, tms_q);
            tdi_q <= 1'b0;
            cap_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == LEN_W'(6)) begin
                        tms_q  <= 1'b0;
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                        tlr_q  <= 1'b0;
                        if (tlr_q) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state_q     <= ST_READY;
                            cmd_ready_q <= 1'b1;
                        end
                    end else begin
                        tms_q <= (cnt_q < LEN_W'(5));
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                ST_READY: begin
                    tms_q <= 1'b0;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        len_q       <= cmd_len;
                        ir_q        <= (cmd_op == OP_IR);
                        cnt_q       <= LEN_W'(1);
                        case (cmd_op)
                            OP_TLR: begin
                                state_q <= ST_INIT;
                                tlr_q   <= 1'b1;
                                tms_q   <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                            OP_IR, OP_DR: begin
                                if (len_bad) begin
                                    state_q     <= ST_RESP;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_NAV;
                                    tms_q   <= 1'b1;
                                    busy_q  <= 1'b1;
                                end
                            end
                            default: begin
                                if (cmd_len == '0) begin
                                    state_q     <= ST_RESP;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b0;
                                end else begin
                                    state_q <= ST_RUN;
                                    busy_q  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_NAV: begin
                    if (bit_go) begin
                        state_q   <= ST_SHIFT;
                        tms_q     <= (len_q == LEN_W'(1));
                        tdi_q     <= sr_lsb;
                        cap_q     <= 1'b1;
                        cap_idx_q <= '0;
                        cnt_q     <= LEN_W'(1);
                    end else begin
                        tms_q <= nav_tms[cnt_q[1:0]];
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (bit_go) begin
                        tms_q     <= (cnt_q == len_q - LEN_W'(1));
                        tdi_q     <= sr_lsb;
                        cap_q     <= 1'b1;
                        cap_idx_q <= IDX_W'(cnt_q);
                        cnt_q     <= cnt_q + LEN_W'(1);
                    end else begin
                        state_q <= ST_EXIT;
                        tms_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_EXIT: begin
                    tms_q <= 1'b0;
                    if (cnt_q == '0) begin
                        cnt_q <= LEN_W'(1);
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    tms_q <= 1'b0;
                    if (cnt_q == len_q) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                ST_RESP: begin
                    tms_q <= 1'b0;
                    if (rsp_ready) begin
                        state_q     <= ST_READY;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    tms_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // The TAP must be parked in Run-Test/Idle whenever the host owns the interface
    always @(posedge clk) begin
        if (!reset && (state_q == ST_READY || state_q == ST_RESP))
            assert (tap_q == TAP_IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jtag_seq_ctrl.sv
// Directed-vector bench for jtag_seq_ctrl.
module tb_jtag_seq_ctrl;
    import jtag_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        busy;

    logic        loop_en;
    logic        tdo_drv;
    int          n_vec = 0;
    int          n_err = 0;

    assign tdo = loop_en ? tdi : tdo_drv;

    always #5 clk = ~clk;

    jtag_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drop reset at a negedge and check the 5x1/1x0 TMS walk into Idle
    task automatic release_and_check();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("init_tms", 32'(tms), 32'(k <= 5));
            chk("init_rdy", 32'(cmd_ready), 32'(k == 7));
            chk("init_rspv", 32'(rsp_valid), 32'(0));
        end
        chk("init_busy", 32'(busy), 32'(0));
        chk("init_tap", 32'(dut.tap_q), 32'(TAP_IDLE));
    endtask

    // Present a command; returns at the negedge of the first cycle after acceptance
    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int t;
        t = 0;
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("issue_rdy", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept_rdy_drop", 32'(cmd_ready), 32'(0));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("consume_vld", 32'(rsp_valid), 32'(0));
        chk("consume_rdy", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [8:0]  ir_tms;
        logic [8:0]  ir_tdi;
        logic [8:0]  ir_tdo;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0; cmd_data = '0;
        rsp_ready = 1'b0; loop_en = 1'b0; tdo_drv = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tms", 32'(tms), 32'(1));
        chk("rst_tdi", 32'(tdi), 32'(0));
        chk("rst_rdy", 32'(cmd_ready), 32'(0));
        chk("rst_rspv", 32'(rsp_valid), 32'(0));
        chk("rst_err", 32'(rsp_err), 32'(0));
        chk("rst_data", rsp_data, 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        release_and_check();

        // Shift IR len=3 data=001, TDO pattern 1,0,1 (cycle index k from accept)
        ir_tms = 9'b011000011;
        ir_tdi = 9'b000010000;
        ir_tdo = 9'b001010000;
        issue(2'b01, 6'd3, 32'h1);
        for (int k = 0; k < 9; k++) begin
            chk("ir_tms", 32'(tms), 32'(ir_tms[k]));
            chk("ir_tdi", 32'(tdi), 32'(ir_tdi[k]));
            chk("ir_rspv", 32'(rsp_valid), 32'(0));
            tdo_drv = ir_tdo[k];
            @(negedge clk);
        end
        tdo_drv = 1'b0;
        chk("ir_vld", 32'(rsp_valid), 32'(1));
        chk("ir_data", rsp_data, 32'h5);
        chk("ir_err", 32'(rsp_err), 32'(0));
        chk("ir_busy", 32'(busy), 32'(0));
        chk("ir_tap", 32'(dut.tap_q), 32'(TAP_IDLE));
        consume();

        // Shift DR len=8 A5 with loopback: 3+8+2 = 13
        loop_en = 1'b1;
        issue(2'b10, 6'd8, 32'hA5);
        wait_rsp(lat);
        chk("dr8_lat", 32'(lat), 32'(13));
        chk("dr8_data", rsp_data, 32'hA5);
        chk("dr8_err", 32'(rsp_err), 32'(0));
        consume();

        // Shift DR at max length 32: 3+32+2 = 37
        issue(2'b10, 6'd32, 32'hDEADBEEF);
        wait_rsp(lat);
        chk("dr32_lat", 32'(lat), 32'(37));
        chk("dr32_data", rsp_data, 32'hDEADBEEF);
        consume();
        loop_en = 1'b0;

        // Length 0 rejected
        issue(2'b10, 6'd0, 32'hFFFFFFFF);
        chk("len0_vld", 32'(rsp_valid), 32'(1));
        chk("len0_err", 32'(rsp_err), 32'(1));
        chk("len0_data", rsp_data, 32'(0));
        chk("len0_tms", 32'(tms), 32'(0));
        chk("len0_busy", 32'(busy), 32'(0));
        consume();
        chk("len0_err_clr", 32'(rsp_err), 32'(0));

        // Length 33 rejected
        issue(2'b10, 6'd33, 32'hFFFFFFFF);
        chk("len33_vld", 32'(rsp_valid), 32'(1));
        chk("len33_err", 32'(rsp_err), 32'(1));
        chk("len33_data", rsp_data, 32'(0));
        chk("len33_tms", 32'(tms), 32'(0));
        chk("len33_tap", 32'(dut.tap_q), 32'(TAP_IDLE));
        consume();

        // Response back-pressure for 10 cycles
        loop_en = 1'b1;
        issue(2'b10, 6'd4, 32'h9);
        wait_rsp(lat);
        chk("bp_lat", 32'(lat), 32'(9));
        loop_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_vld", 32'(rsp_valid), 32'(1));
            chk("bp_data", rsp_data, 32'h9);
            chk("bp_rdy", 32'(cmd_ready), 32'(0));
            chk("bp_tms", 32'(tms), 32'(0));
            @(negedge clk);
        end
        consume();

        // Run-idle len=5 and len=0
        issue(2'b11, 6'd5, 32'h0);
        chk("run_busy", 32'(busy), 32'(1));
        wait_rsp(lat);
        chk("run5_lat", 32'(lat), 32'(5));
        chk("run5_data", rsp_data, 32'(0));
        chk("run5_tms", 32'(tms), 32'(0));
        consume();
        issue(2'b11, 6'd0, 32'h0);
        chk("run0_vld", 32'(rsp_valid), 32'(1));
        chk("run0_err", 32'(rsp_err), 32'(0));
        consume();

        // TLR op: 5x tms=1, 1x tms=0, then response
        issue(2'b00, 6'd0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            chk("tlr_tms", 32'(tms), 32'(k < 5));
            chk("tlr_busy", 32'(busy), 32'(1));
            @(negedge clk);
        end
        chk("tlr_vld", 32'(rsp_valid), 32'(1));
        chk("tlr_err", 32'(rsp_err), 32'(0));
        chk("tlr_data", rsp_data, 32'(0));
        chk("tlr_tap", 32'(dut.tap_q), 32'(TAP_IDLE));
        consume();

        // Reset in the middle of a 16-bit DR shift
        loop_en = 1'b1;
        issue(2'b10, 6'd16, 32'h1234);
        repeat (6) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_tms", 32'(tms), 32'(1));
        chk("mid_tdi", 32'(tdi), 32'(0));
        chk("mid_rspv", 32'(rsp_valid), 32'(0));
        chk("mid_rdy", 32'(cmd_ready), 32'(0));
        chk("mid_busy_rst", 32'(busy), 32'(1));
        chk("mid_data", rsp_data, 32'(0));
        release_and_check();
        loop_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_stale", 32'(rsp_valid), 32'(0));
        issue(2'b11, 6'd2, 32'h0);
        wait_rsp(lat);
        chk("post_run_lat", 32'(lat), 32'(2));
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
